shab90_4096x16x1cm16: RTL and testbench
=======================================

Name: shab90_4096x16x1cm16

Overview:
Single-port synchronous SRAM macro model: 4096 words x 16 bits, one address bus shared by read and write. It is the data buffer for the k-means clustering engine. The engine writes 4096 packed (x[15:8], y[7:0]) points, then streams them back repeatedly by address. Read data is registered, so DO lags the address by one clock.

Parameters:
ADDR_W, 12, address width in bits.
DATA_W, 16, word width in bits.
DEPTH, 4096, number of words; must equal 2**ADDR_W.

Ports:
clk  input  1  clock; all activity on the rising edge (the macro pin CK maps here).
rst_n  input  1  synchronous active-low reset.
A  input  ADDR_W  word address, sampled at the rising edge.
DI  input  DATA_W  write data, sampled at the rising edge.
DO  output  DATA_W  read data.
WEB  input  1  write enable, active low.
OE  input  1  output enable, active high.
CS  input  1  chip select, active high.

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: rst_n is sampled only at the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - The internal read-data register clears to 0, so DO=0 whenever OE=1.
  - No read or write occurs in that cycle.
  - Array contents are preserved unless SHAB90_RESET_CLEAR_EN is defined.
- Access conditions, all sampled at the rising edge with rst_n=1:
  - CS=0: no access. Array unchanged; read register holds its value.
  - CS=1, WEB=0 (write): mem[A] <= DI. The read register also loads DI (write-through), so DO shows the written data the next cycle.
  - CS=1, WEB=1 (read): read register <= mem[A]. Data appears on DO after the edge, giving 1-cycle read latency.
- Back-to-back accesses: any mix of reads and writes at consecutive addresses, one per cycle, with no bubbles.
- A read of an address written in the previous cycle returns the new data.
- Output: DO = read register when OE=1. DO = 0 when OE=0 (driven low, never tri-stated). OE is purely combinational on DO.
- Addresses: A spans exactly DEPTH, so there is no out-of-range case. Address 4095 is a valid word, and there is no auto-increment or wrap logic inside the block.
- Never-written words read as 0. The array is initialised to 0 at time zero in simulation.
- WEB or CS toggling mid-stream takes effect at the next edge only. There are no combinational paths from A, DI, WEB or CS to DO.

Optional Feature:
Macro SHAB90_RESET_CLEAR_EN.
- Defined: while rst_n=0, the array is cleared one word per clock from address 0 upward using an internal ADDR_W counter. The counter restarts at 0 on each reset assertion. Once rst_n is deasserted the clear stops, and only words reached so far are guaranteed 0.
- Not defined: reset affects only the read register; array contents survive reset.

Decomposition:
- Shared package holds ADDR_W, DATA_W and DEPTH constants, plus a word typedef (logic [DATA_W-1:0]) used by the k-means engine.
- One natural sub-module, shab90_array_core: the raw storage plus write port, parameterised by DEPTH and DATA_W.
- The top level keeps CS/WEB decode, the read register, the OE gating and the optional clear counter.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release, read address 0 with CS=1, WEB=1, OE=1 -> DO=0x0000 the cycle after the read edge.
- Write then read: write 0x1234@0x000, 0xABCD@0xFFF, 0x00FF@0x7A5 on consecutive cycles, then read each address -> each read data appears exactly 1 cycle after its address edge.
- Full sweep: write addr^0x5A5A to all 4096 addresses, then read all 4096 back-to-back -> every word matches with no mismatches or bubbles.
- Write-through: write 0xBEEF@0x010 -> DO=0xBEEF next cycle; an immediate read of 0x010 -> 0xBEEF.
- CS and OE gating:
  - With CS=0, WEB=0, DI=0xFFFF at 0x010 -> mem[0x010] unchanged (still 0xBEEF) and DO holds its prior value.
  - OE=0 -> DO=0x0000 in the same cycle; OE back to 1 -> DO restored to the held value.
- Reset mid-stream: assert rst_n=0 for 1 cycle during a read sequence -> DO=0 next cycle. Reading 0x7A5 afterwards -> 0x00FF without the macro; with the macro, addresses beyond the clear counter still hold their data.

Source files
------------

// File: rtl/shab90_4096x16x1cm16_pkg.sv
// Shared constants and word type for the 4096x16 k-means point buffer.
// Points are packed as {x[7:0], y[7:0]} into one word.
package shab90_4096x16x1cm16_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/shab90_4096x16x1cm16_array_core.sv
// Raw storage for the point buffer: one synchronous write port, and an
// unregistered read of the same address (the top owns the output register).
module shab90_array_core #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/shab90_4096x16x1cm16.sv
// Single-port 4096x16 SRAM model with registered read data and OE gating.
// Optional SHAB90_RESET_CLEAR_EN: clear the array one word per clock while rst_n is low.
module shab90_4096x16x1cm16 #(
  parameter int ADDR_W = shab90_4096x16x1cm16_pkg::ADDR_W,
  parameter int DATA_W = shab90_4096x16x1cm16_pkg::DATA_W,
  parameter int DEPTH  = shab90_4096x16x1cm16_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              OE,
  input  logic              CS
);
  import shab90_4096x16x1cm16_pkg::*;

  logic              acc_wr, acc_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd, mem_rd;
  logic [DATA_W-1:0] rd_q;

  // Reset blocks any access in its cycle.
  assign acc_wr = rst_n &  CS & ~WEB;
  assign acc_rd = rst_n &  CS &  WEB;

`ifdef SHAB90_RESET_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  // Held at 0 while running so every reset assertion starts clearing from word 0.
  always_ff @(posedge clk) begin
    if (rst_n) clr_cnt <= '0;
    else       clr_cnt <= clr_cnt + 1'b1;
  end

  assign mem_we   = acc_wr | ~rst_n;
  assign mem_addr = rst_n ? A  : clr_cnt;
  assign mem_wd   = rst_n ? DI : '0;
`else
  assign mem_we   = acc_wr;
  assign mem_addr = A;
  assign mem_wd   = DI;
`endif

  shab90_array_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wd),
    .rdata (mem_rd)
  );

  // Writes load the read register too, so DO shows the written word next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)      rd_q <= '0;
    else if (acc_wr) rd_q <= DI;
    else if (acc_rd) rd_q <= mem_rd;
  end

  assign DO = OE ? rd_q : '0;

endmodule

// File: tb/tb_shab90_4096x16x1cm16.sv
// Directed self-checking bench for the 4096x16 single-port SRAM model.
module tb_shab90_4096x16x1cm16;

  logic        clk;
  logic        rst_n;
  logic [11:0] A;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        WEB, OE, CS;

  int n_tests = 0;
  int n_fail  = 0;

  shab90_4096x16x1cm16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .DI    (DI),
    .DO    (DO),
    .WEB   (WEB),
    .OE    (OE),
    .CS    (CS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    CS = 1'b1; WEB = 1'b0; A = a; DI = d;
    cyc();
  endtask

  task automatic rd(input logic [11:0] a);
    CS = 1'b1; WEB = 1'b1; A = a;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    rst_n = 1'b0; CS = 1'b0; WEB = 1'b1; OE = 1'b1; A = '0; DI = '0;
    #1;
    cyc(); cyc();
    chk("reset_do", DO, 16'h0000);
    rst_n = 1'b1;
    rd(12'h000);
    chk("unwritten_rd0", DO, 16'h0000);

    // Consecutive writes, each visible through write-through.
    wr(12'h000, 16'h1234); chk("wt_000", DO, 16'h1234);
    wr(12'hFFF, 16'hABCD); chk("wt_fff", DO, 16'hABCD);
    wr(12'h7A5, 16'h00FF); chk("wt_7a5", DO, 16'h00FF);

    // Read latency: DO must not move before the edge.
    CS = 1'b1; WEB = 1'b1; A = 12'h000;
    #1;
    chk("no_comb_path", DO, 16'h00FF);
    cyc();
    chk("rd_000", DO, 16'h1234);
    rd(12'hFFF); chk("rd_fff", DO, 16'hABCD);
    rd(12'h7A5); chk("rd_7a5", DO, 16'h00FF);

    // Full sweep, write then back-to-back read.
    for (int i = 0; i < 4096; i++) wr(i[11:0], i[15:0] ^ 16'h5A5A);
    for (int i = 0; i < 4096; i++) begin
      rd(i[11:0]);
      pat = i[15:0] ^ 16'h5A5A;
      chk($sformatf("sweep_%03h", i), DO, pat);
    end

    // Write-through and read-after-write.
    wr(12'h010, 16'hBEEF); chk("wt_010", DO, 16'hBEEF);
    rd(12'h010);           chk("raw_010", DO, 16'hBEEF);

    // CS gating: deselected write must neither store nor disturb DO.
    CS = 1'b0; WEB = 1'b0; A = 12'h010; DI = 16'hFFFF;
    cyc();
    chk("cs0_hold", DO, 16'hBEEF);
    CS = 1'b0; WEB = 1'b1; A = 12'h000;
    cyc();
    chk("cs0_rd_hold", DO, 16'hBEEF);
    rd(12'h000); chk("rd_000_sweep", DO, 16'h5A5A);
    rd(12'h010); chk("cs0_mem_kept", DO, 16'hBEEF);

    // OE is combinational.
    OE = 1'b0; #1; chk("oe0", DO, 16'h0000);
    OE = 1'b1; #1; chk("oe1", DO, 16'hBEEF);

    // Reset mid-stream, with a write attempted during reset.
    wr(12'h7A5, 16'h00FF);
    rd(12'h100); chk("rd_100", DO, 16'h5B5A);
    rst_n = 1'b0; CS = 1'b1; WEB = 1'b0; A = 12'h200; DI = 16'h1111;
    cyc();
    chk("mid_reset_do", DO, 16'h0000);
    rst_n = 1'b1;
    rd(12'h7A5); chk("post_rst_7a5", DO, 16'h00FF);
    rd(12'h200); chk("rst_blocks_wr", DO, 16'h585A);
    rd(12'hFFF); chk("post_rst_fff", DO, 16'h5A5A ^ 16'h0FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
